merge_ctrl_param: RTL and testbench
===================================

Name: merge_ctrl_param

Overview:
- Parametrised successor of the two-input merge control unit in the merge-sort tree.
- Consumes two input FIFOs of sorted runs. Each run is terminated by a zero-key record.
- Merges one run from A with one run from B into a single output run and emits one terminator per merged run.
- Optionally toggles the output steering select after each run. Adds a run-length counter, descending mode, and a registered output write port.

Parameters:
- DATA_W, 32, record width in bits.
- KEY_W, 32, sort key width; the key is bits [KEY_W-1:0] of a record; KEY_W <= DATA_W.
- DESCEND, 0, 0 = ascending merge (smaller key first), 1 = descending (larger key first).
- SWITCH_EN, 1, 1 = toggle o_switch_output after each emitted terminator; 0 = hold at 0.
- CNT_W, 16, width of the run-length counter.

Ports:
- i_clk, in, 1, clock, rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_a_data, in, DATA_W, head record of FIFO A.
- i_a_empty, in, 1, FIFO A empty.
- o_a_deq, out, 1, dequeue FIFO A this cycle (combinational).
- i_b_data, in, DATA_W, head record of FIFO B.
- i_b_empty, in, 1, FIFO B empty.
- o_b_deq, out, 1, dequeue FIFO B this cycle (combinational).
- i_fifo_out_full, in, 1, output FIFO almost-full (asserted with at least 1 free slot remaining).
- o_out_data, out, DATA_W, registered output record.
- o_out_wr, out, 1, registered write strobe for o_out_data.
- o_select_a, out, 1, combinational; 1 when A is dequeued and written this cycle.
- o_stall, out, 1, combinational; 1 when no transfer occurs this cycle.
- o_switch_output, out, 1, registered output-FIFO select.
- o_run_count, out, CNT_W, registered count of data records written in the current run; saturates at all-ones.

Behaviour:
- Terminator: a record whose key field is 0; its payload bits are ignored. Emitted terminators are all-zero DATA_W.
- "Before" comparison:
  - DESCEND=0: A goes before B when keyA <= keyB.
  - DESCEND=1: A goes before B when keyA >= keyB.
  - Ties always go to A. Keys are unsigned.
- States, reset value MERGE:
  - MERGE:
    - Requires !i_a_empty & !i_b_empty.
    - Both heads terminators: deq A and B, write terminator, stay in MERGE.
    - Only A head terminator: deq A, no write, go to DRAIN_B.
    - Only B head terminator: deq B, no write, go to DRAIN_A.
    - Neither head terminator: deq and write the "before" head; o_select_a = 1 if that head is A.
  - DRAIN_B:
    - Requires !i_b_empty.
    - Data head: deq and write B.
    - Terminator head: deq B, write terminator, go to MERGE.
  - DRAIN_A: mirror of DRAIN_B for FIFO A; o_select_a = 1 on every A data write.
- Stall:
  - o_stall = 1 when a required FIFO is empty, or the action would write and i_fifo_out_full = 1.
  - Consume-only actions (the MERGE single-terminator cases) do not need output space.
  - During stall: no deq, no write, state held, o_select_a = 0.
- Latency: the record dequeued in cycle N appears as o_out_data with o_out_wr = 1 in cycle N+1. o_out_wr is low in every cycle after a non-writing cycle.
- Terminator write effects, registered with the write:
  - o_run_count <= 0.
  - o_switch_output toggles if SWITCH_EN = 1.
  - The terminator itself carries the pre-toggle select: o_switch_output updates the cycle after the terminator's o_out_wr.
- Data write: o_run_count increments, saturating at 2^CNT_W-1.
- Empty runs: a run of length 0 (a terminator at the head with no data) on both inputs produces a lone terminator. o_run_count stays 0.
- Reset: asserting i_rst_n low at any time, including mid-run, immediately sets:
  - state = MERGE
  - o_out_wr = 0, o_out_data = 0
  - o_switch_output = 0, o_run_count = 0
  - No deq while in reset.
- Inputs of X on an empty FIFO's data must not affect outputs.

Test Plan:
- Ascending merge: A = {3,7,0}, B = {5,9,0}, DESCEND=0 -> output stream 3,5,7,9,0; o_select_a over the data writes = 1,0,1,0; o_run_count reaches 4, then 0; o_switch_output goes 0→1 one cycle after the terminator write.
- Ties and descending: A = {8,8,0}, B = {8,2,0}, DESCEND=1 -> output 8(A),8(A),8(B),2(B),0.
- Stall: i_b_empty = 1 in MERGE with A non-empty -> o_stall = 1, no deq, o_select_a = 0. i_fifo_out_full = 1 mid-run for 3 cycles -> no writes; the stream resumes unchanged afterwards.
- Unequal and empty runs: A = {0}, B = {4,6,0} -> output 4,6,0. Then A = {0}, B = {0} -> a single 0 written; o_run_count stays 0; o_switch_output toggles again. With SWITCH_EN=0, o_switch_output stays 0 throughout.
- Saturation: CNT_W=2, A = {1,2,3,4,5,0}, B = {0} -> o_run_count sequence 1,2,3,3,3, then 0.
- Async reset: drive i_rst_n low in DRAIN_A between clock edges -> outputs clear without waiting for a clock edge. After release, a fresh A = {1,0}, B = {2,0} merges to 1,2,0.

Source files
------------

// File: rtl/merge_ctrl_param.sv
// Two-input merge control for the merge-sort tree: merges one zero-key-terminated run from
// FIFO A with one from FIFO B, emitting a single terminator per merged run.
module merge_ctrl_param #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned KEY_W     = 32,
  parameter bit          DESCEND   = 1'b0,
  parameter bit          SWITCH_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_empty,
  output logic              o_a_deq,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_empty,
  output logic              o_b_deq,
  input  logic              i_fifo_out_full,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_wr,
  output logic              o_select_a,
  output logic              o_stall,
  output logic              o_switch_output,
  output logic [CNT_W-1:0]  o_run_count
);

  typedef enum logic [1:0] {
    StMerge  = 2'd0,
    StDrainA = 2'd1,
    StDrainB = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_wr;
  logic                r_switch;
  logic                r_term_q;
  logic [CNT_W-1:0]    r_run_count;

  logic [KEY_W-1:0]    w_a_key;
  logic [KEY_W-1:0]    w_b_key;
  logic                w_a_term;
  logic                w_b_term;
  logic                w_a_before;
  logic                w_a_deq;
  logic                w_b_deq;
  logic                w_wr;
  logic                w_wr_term;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_sel_a;
  logic                w_stall;

  assign w_a_key    = i_a_data[KEY_W-1:0];
  assign w_b_key    = i_b_data[KEY_W-1:0];
  assign w_a_term   = (w_a_key == '0);
  assign w_b_term   = (w_b_key == '0);
  // Ties resolve to A in both directions.
  assign w_a_before = DESCEND ? (w_a_key >= w_b_key) : (w_a_key <= w_b_key);

  // Empty flags are tested first so head data of an empty FIFO never steers a decision.
  always_comb begin
    w_state_nxt = r_state;
    w_a_deq     = 1'b0;
    w_b_deq     = 1'b0;
    w_wr        = 1'b0;
    w_wr_term   = 1'b0;
    w_wr_data   = '0;
    w_sel_a     = 1'b0;
    w_stall     = 1'b0;
    if (!i_rst_n) begin
      w_stall = 1'b1;
    end else begin
      unique case (r_state)
        StMerge: begin
          if (i_a_empty || i_b_empty) begin
            w_stall = 1'b1;
          end else if (w_a_term && w_b_term) begin
            if (i_fifo_out_full) begin
              w_stall = 1'b1;
            end else begin
              w_a_deq   = 1'b1;
              w_b_deq   = 1'b1;
              w_wr      = 1'b1;
              w_wr_term = 1'b1;
            end
          end else if (w_a_term) begin
            w_a_deq     = 1'b1;
            w_state_nxt = StDrainB;
          end else if (w_b_term) begin
            w_b_deq     = 1'b1;
            w_state_nxt = StDrainA;
          end else if (i_fifo_out_full) begin
            w_stall = 1'b1;
          end else if (w_a_before) begin
            w_a_deq   = 1'b1;
            w_wr      = 1'b1;
            w_wr_data = i_a_data;
            w_sel_a   = 1'b1;
          end else begin
            w_b_deq   = 1'b1;
            w_wr      = 1'b1;
            w_wr_data = i_b_data;
          end
        end
        StDrainB: begin
          if (i_b_empty || i_fifo_out_full) begin
            w_stall = 1'b1;
          end else begin
            w_b_deq = 1'b1;
            w_wr    = 1'b1;
            if (w_b_term) begin
              w_wr_term   = 1'b1;
              w_state_nxt = StMerge;
            end else begin
              w_wr_data = i_b_data;
            end
          end
        end
        StDrainA: begin
          if (i_a_empty || i_fifo_out_full) begin
            w_stall = 1'b1;
          end else begin
            w_a_deq = 1'b1;
            w_wr    = 1'b1;
            if (w_a_term) begin
              w_wr_term   = 1'b1;
              w_state_nxt = StMerge;
            end else begin
              w_wr_data = i_a_data;
              w_sel_a   = 1'b1;
            end
          end
        end
        default: begin
          w_stall     = 1'b1;
          w_state_nxt = StMerge;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StMerge;
      r_out_data  <= '0;
      r_out_wr    <= 1'b0;
      r_switch    <= 1'b0;
      r_term_q    <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_out_wr <= w_wr;
      r_term_q <= w_wr & w_wr_term;
      if (w_wr) begin
        r_out_data <= w_wr_data;
        if (w_wr_term) begin
          r_run_count <= '0;
        end else if (!(&r_run_count)) begin
          r_run_count <= r_run_count + CNT_W'(1);
        end
      end
      // Toggle lags the terminator strobe so the terminator leaves on the old select.
      if (SWITCH_EN && r_term_q) begin
        r_switch <= ~r_switch;
      end
    end
  end

  assign o_a_deq         = w_a_deq;
  assign o_b_deq         = w_b_deq;
  assign o_select_a      = w_sel_a;
  assign o_stall         = w_stall;
  assign o_out_data      = r_out_data;
  assign o_out_wr        = r_out_wr;
  assign o_switch_output = r_switch;
  assign o_run_count     = r_run_count;

endmodule

// File: tb/tb_merge_ctrl_param.sv
// Directed bench: u0 is ascending with select toggling; u1 is descending, toggle off, 2-bit count.
module tb_merge_ctrl_param;

  typedef struct {
    logic [31:0] d;
    logic [31:0] c;
    logic        sel;
    logic        sw;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        full;

  logic [31:0] a_data0, b_data0, out_data0, a_data1, b_data1, out_data1;
  logic        a_empty0, b_empty0, a_deq0, b_deq0, out_wr0, sel0, stall0, sw0;
  logic        a_empty1, b_empty1, a_deq1, b_deq1, out_wr1, sel1, stall1, sw1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  logic [31:0] qa0[$], qb0[$], qa1[$], qb1[$];
  rec_t        log0[$], log1[$];
  logic        cap_da0, cap_db0, cap_sa0, cap_da1, cap_db1, cap_sa1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  merge_ctrl_param u0 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_a_data       (a_data0),
    .i_a_empty      (a_empty0),
    .o_a_deq        (a_deq0),
    .i_b_data       (b_data0),
    .i_b_empty      (b_empty0),
    .o_b_deq        (b_deq0),
    .i_fifo_out_full(full),
    .o_out_data     (out_data0),
    .o_out_wr       (out_wr0),
    .o_select_a     (sel0),
    .o_stall        (stall0),
    .o_switch_output(sw0),
    .o_run_count    (cnt0)
  );

  merge_ctrl_param #(
    .DESCEND  (1'b1),
    .SWITCH_EN(1'b0),
    .CNT_W    (2)
  ) u1 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_a_data       (a_data1),
    .i_a_empty      (a_empty1),
    .o_a_deq        (a_deq1),
    .i_b_data       (b_data1),
    .i_b_empty      (b_empty1),
    .o_b_deq        (b_deq1),
    .i_fifo_out_full(full),
    .o_out_data     (out_data1),
    .o_out_wr       (out_wr1),
    .o_select_a     (sel1),
    .o_stall        (stall1),
    .o_switch_output(sw1),
    .o_run_count    (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: present FIFO heads (garbage when empty), then sample deq/select.
  task automatic apply_sample();
    a_empty0 = (qa0.size() == 0);
    a_data0  = a_empty0 ? $urandom : qa0[0];
    b_empty0 = (qb0.size() == 0);
    b_data0  = b_empty0 ? $urandom : qb0[0];
    a_empty1 = (qa1.size() == 0);
    a_data1  = a_empty1 ? $urandom : qa1[0];
    b_empty1 = (qb1.size() == 0);
    b_data1  = b_empty1 ? $urandom : qb1[0];
    #1;
    cap_da0 = a_deq0;
    cap_db0 = b_deq0;
    cap_sa0 = sel0;
    cap_da1 = a_deq1;
    cap_db1 = b_deq1;
    cap_sa1 = sel1;
  endtask

  task automatic finish_cycle();
    rec_t r;
    @(posedge clk);
    #1;
    if (cap_da0) void'(qa0.pop_front());
    if (cap_db0) void'(qb0.pop_front());
    if (cap_da1) void'(qa1.pop_front());
    if (cap_db1) void'(qb1.pop_front());
    @(negedge clk);
    if (out_wr0) begin
      r.d = out_data0; r.c = 32'(cnt0); r.sel = cap_sa0; r.sw = sw0;
      log0.push_back(r);
    end
    if (out_wr1) begin
      r.d = out_data1; r.c = 32'(cnt1); r.sel = cap_sa1; r.sw = sw1;
      log1.push_back(r);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      apply_sample();
      finish_cycle();
    end
  endtask

  task automatic chk_rec(input int dut, input string tag, input logic [31:0] d,
                         input logic [31:0] c, input logic sel, input logic sw);
    rec_t r;
    if ((dut == 0 && log0.size() == 0) || (dut == 1 && log1.size() == 0)) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=no record written expected=data %0h", tag, d);
      return;
    end
    r = (dut == 0) ? log0.pop_front() : log1.pop_front();
    chk({tag, ".data"}, r.d, d);
    chk({tag, ".cnt"}, r.c, c);
    chk({tag, ".sel_a"}, 32'(r.sel), 32'(sel));
    chk({tag, ".switch"}, 32'(r.sw), 32'(sw));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    full  = 1'b0;
    // Heads present during reset must not be dequeued.
    qa0 = '{32'd3, 32'd7, 32'd0};
    qb0 = '{32'd5, 32'd9, 32'd0};
    repeat (2) @(negedge clk);
    apply_sample();
    chk("rst.out_wr", 32'(out_wr0), 32'd0);
    chk("rst.out_data", out_data0, 32'd0);
    chk("rst.switch", 32'(sw0), 32'd0);
    chk("rst.count", 32'(cnt0), 32'd0);
    chk("rst.a_deq", 32'(a_deq0), 32'd0);
    chk("rst.b_deq", 32'(b_deq0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // B empty in MERGE: stall with nothing dequeued.
    qb0.delete();
    apply_sample();
    chk("bempty.stall", 32'(stall0), 32'd1);
    chk("bempty.a_deq", 32'(a_deq0), 32'd0);
    chk("bempty.sel_a", 32'(sel0), 32'd0);
    finish_cycle();

    // Ascending merge on u0, descending ties on u1, output full for 3 cycles mid-run.
    qb0 = '{32'd5, 32'd9, 32'd0};
    qa1 = '{32'd8, 32'd8, 32'd0};
    qb1 = '{32'd8, 32'd2, 32'd0};
    cyc(2);
    full = 1'b1;
    apply_sample();
    chk("full.stall", 32'(stall0), 32'd1);
    chk("full.a_deq", 32'(a_deq0), 32'd0);
    chk("full.b_deq", 32'(b_deq0), 32'd0);
    finish_cycle();
    cyc(1);
    chk("full.out_wr", 32'(out_wr0), 32'd0);
    cyc(1);
    full = 1'b0;
    cyc(8);
    chk_rec(0, "asc0", 32'd3, 32'd1, 1'b1, 1'b0);
    chk_rec(0, "asc1", 32'd5, 32'd2, 1'b0, 1'b0);
    chk_rec(0, "asc2", 32'd7, 32'd3, 1'b1, 1'b0);
    chk_rec(0, "asc3", 32'd9, 32'd4, 1'b0, 1'b0);
    chk_rec(0, "asc4", 32'd0, 32'd0, 1'b0, 1'b0);
    chk("asc.switch_after", 32'(sw0), 32'd1);
    chk_rec(1, "dsc0", 32'd8, 32'd1, 1'b1, 1'b0);
    chk_rec(1, "dsc1", 32'd8, 32'd2, 1'b1, 1'b0);
    chk_rec(1, "dsc2", 32'd8, 32'd3, 1'b0, 1'b0);
    chk_rec(1, "dsc3", 32'd2, 32'd3, 1'b0, 1'b0);
    chk_rec(1, "dsc4", 32'd0, 32'd0, 1'b0, 1'b0);

    // Empty A run then two empty runs on u0; count saturation on u1.
    qa0 = '{32'd0, 32'd0};
    qb0 = '{32'd4, 32'd6, 32'd0, 32'd0};
    qa1 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    qb1 = '{32'd0};
    cyc(10);
    chk_rec(0, "emp0", 32'd4, 32'd1, 1'b0, 1'b1);
    chk_rec(0, "emp1", 32'd6, 32'd2, 1'b0, 1'b1);
    chk_rec(0, "emp2", 32'd0, 32'd0, 1'b0, 1'b1);
    chk_rec(0, "emp3", 32'd0, 32'd0, 1'b0, 1'b0);
    chk("emp.switch_after", 32'(sw0), 32'd1);
    chk_rec(1, "sat0", 32'd1, 32'd1, 1'b1, 1'b0);
    chk_rec(1, "sat1", 32'd2, 32'd2, 1'b1, 1'b0);
    chk_rec(1, "sat2", 32'd3, 32'd3, 1'b1, 1'b0);
    chk_rec(1, "sat3", 32'd4, 32'd3, 1'b1, 1'b0);
    chk_rec(1, "sat4", 32'd5, 32'd3, 1'b1, 1'b0);
    chk_rec(1, "sat5", 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sat.switch_held", 32'(sw1), 32'd0);

    // Async reset while u0 drains A, asserted between clock edges.
    qa0 = '{32'd1, 32'd2, 32'd3, 32'd0};
    qb0 = '{32'd0};
    cyc(3);
    chk_rec(0, "pre0", 32'd1, 32'd1, 1'b1, 1'b1);
    chk_rec(0, "pre1", 32'd2, 32'd2, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_wr", 32'(out_wr0), 32'd0);
    chk("arst.out_data", out_data0, 32'd0);
    chk("arst.count", 32'(cnt0), 32'd0);
    chk("arst.switch", 32'(sw0), 32'd0);
    chk("arst.a_deq", 32'(a_deq0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    qa0 = '{32'd1, 32'd0};
    qb0 = '{32'd2, 32'd0};
    cyc(8);
    chk_rec(0, "post0", 32'd1, 32'd1, 1'b1, 1'b0);
    chk_rec(0, "post1", 32'd2, 32'd2, 1'b0, 1'b0);
    chk_rec(0, "post2", 32'd0, 32'd0, 1'b0, 1'b0);
    chk("post.switch_after", 32'(sw0), 32'd1);
    chk("extra0", 32'(log0.size()), 32'd0);
    chk("extra1", 32'(log1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
